// File: rtl/iobuf_loopback_tester_pkg.sv
// Shared types and check rules for the IOBUF pad loopback tester.
// Vector layout is {ext_o, io_t, io_i}.
package iobuf_loopback_tester_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StCheck,
        StNext,
        StDone
    } state_e;

    typedef logic [2:0] vec_t;

    // Mode 1 with the pad driven against a differing ext_o would be driver contention.
    function automatic logic skip(input logic mode, input vec_t vec);
        return mode && !vec[1] && (vec[2] != vec[0]);
    endfunction

    function automatic logic exp_ok(input logic mode, input vec_t vec,
                                    input logic io_o_s, input logic ext_i_s);
        logic ok;
        if (!vec[1]) begin
            ok = (io_o_s == vec[0]) && (mode || (ext_i_s == vec[0]));
        end else begin
            ok = !mode || (io_o_s == vec[2]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/iobuf_loopback_tester_if.sv
// Pad-control, readback and status bundle between the tester and the board.
// master = tester side, slave = board/host side.
interface iobuf_loopback_tester_if #(
    parameter int unsigned ERR_W = 8
);
    logic             start;
    logic             mode;
    logic             io_i;
    logic             io_t;
    logic             ext_o;
    logic             io_o;
    logic             ext_i;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [ERR_W-1:0] err_cnt;
    logic [2:0]       fail_vec;

    modport master (
        input  start, mode, io_o, ext_i,
        output io_i, io_t, ext_o, busy, done, pass, fail, err_cnt, fail_vec
    );

    modport slave (
        output start, mode, io_o, ext_i,
        input  io_i, io_t, ext_o, busy, done, pass, fail, err_cnt, fail_vec
    );
endinterface

// File: rtl/iobuf_loopback_tester_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/iobuf_loopback_tester.sv
// Walks the eight {ext_o,io_t,io_i} vectors through a jumpered IOBUF pad and checks the readback.
// IOBUF_LOOPBACK_TESTER_CONTINUOUS_EN: when defined, DONE auto-restarts and error state accumulates.
module iobuf_loopback_tester
    import iobuf_loopback_tester_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned ERR_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    iobuf_loopback_tester_if.master bus
);

`ifdef IOBUF_LOOPBACK_TESTER_CONTINUOUS_EN
    localparam bit Continuous = 1'b1;
`else
    localparam bit Continuous = 1'b0;
`endif

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 3 to cover the synchroniser latency");
    end

    state_e           r_state;
    vec_t             r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_io_i;
    logic             r_io_t;
    logic             r_ext_o;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_fail;
    logic [ERR_W-1:0] r_err_cnt;
    vec_t             r_fail_vec;

    logic w_io_o_s;
    logic w_ext_i_s;
    logic w_mismatch;
    logic w_any_err;

    sync_2ff u_sync_io_o (
        .clk (clk),
        .rst (rst),
        .i_d (bus.io_o),
        .o_q (w_io_o_s)
    );

    sync_2ff u_sync_ext_i (
        .clk (clk),
        .rst (rst),
        .i_d (bus.ext_i),
        .o_q (w_ext_i_s)
    );

    assign w_mismatch = (r_state == StCheck) && !exp_ok(r_mode, r_vec, w_io_o_s, w_ext_i_s);
    // Error state as it will be after this cycle, so pass/fail register correctly on entry to DONE.
    assign w_any_err  = (r_err_cnt != '0) || w_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_vec      <= '0;
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_io_i     <= 1'b0;
            r_io_t     <= 1'b1;
            r_ext_o    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_err_cnt  <= '0;
            r_fail_vec <= '0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (Continuous && (r_state == StDone)) begin
                        r_state <= StApply;
                        r_vec   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b0;
                    end else if (bus.start) begin
                        r_state    <= StApply;
                        r_vec      <= '0;
                        r_mode     <= bus.mode;
                        r_err_cnt  <= '0;
                        r_fail_vec <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_fail     <= 1'b0;
                    end
                end
                StApply: begin
                    if (skip(r_mode, r_vec)) begin
                        r_state <= StNext;
                    end else begin
                        {r_ext_o, r_io_t, r_io_i} <= r_vec;
                        r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                        r_state <= StSettle;
                    end
                end
                StSettle: begin
                    if (r_cnt == '0) begin
                        r_state <= StCheck;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StCheck, StNext: begin
                    if (w_mismatch) begin
                        if (!(&r_err_cnt)) begin
                            r_err_cnt <= r_err_cnt + ERR_W'(1);
                        end
                        if (r_err_cnt == '0) begin
                            r_fail_vec <= r_vec;
                        end
                    end
                    if (r_vec == 3'd7) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= !w_any_err;
                        r_fail  <= w_any_err;
                        r_io_t  <= 1'b1;
                        r_io_i  <= 1'b0;
                        r_ext_o <= 1'b0;
                    end else begin
                        r_vec   <= r_vec + 3'd1;
                        r_state <= StApply;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.io_i     = r_io_i;
    assign bus.io_t     = r_io_t;
    assign bus.ext_o    = r_ext_o;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pass     = r_pass;
    assign bus.fail     = r_fail;
    assign bus.err_cnt  = r_err_cnt;
    assign bus.fail_vec = r_fail_vec;

endmodule

// File: tb/tb_iobuf_loopback_tester.sv
// Bench for iobuf_loopback_tester: jumpered-pad board model plus a vector-level reference model.
module tb_iobuf_loopback_tester;

    localparam int unsigned S = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic a_jmp = 1'b0;
    int   a_flt = 0;

    iobuf_loopback_tester_if #(.ERR_W(8)) a_if ();
    iobuf_loopback_tester_if #(.ERR_W(1)) b_if ();

    iobuf_loopback_tester #(.SETTLE_CYCLES(S), .ERR_W(8)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    iobuf_loopback_tester #(.SETTLE_CYCLES(S), .ERR_W(1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    // Board: jumper 0 ties pad to ext_i, jumper 1 ties pad to ext_o; a released pad reads 0.
    // Fault 1 = ext_i stuck at 0, fault 2 = pad stuck at 1. Returns {io_o, ext_i}.
    function automatic logic [1:0] board(input logic jmp, input int flt, input logic ii,
                                         input logic t, input logic eo);
        logic pad;
        logic ext;
        if (!jmp) pad = t ? 1'b0 : ii;
        else      pad = t ? eo : ii;
        if (flt == 2) pad = 1'b1;
        ext = jmp ? 1'b0 : pad;
        if (flt == 1) ext = 1'b0;
        return {pad, ext};
    endfunction

    always_comb {a_if.io_o, a_if.ext_i} = board(a_jmp, a_flt, a_if.io_i, a_if.io_t, a_if.ext_o);
    assign b_if.io_o  = 1'b1;
    assign b_if.ext_i = 1'b0;

    // Expected run length, error count and first failing vector for one full pass.
    task automatic model(input logic m, input int flt, input int errmax,
                         output int cyc, output int errs, output logic [2:0] fv);
        cyc  = 0;
        errs = 0;
        fv   = 3'b000;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vb;
            logic [1:0] rd;
            logic       ok;
            vb = 3'(v);
            if (m && !vb[1] && (vb[2] != vb[0])) begin
                cyc += 2;
            end else begin
                cyc += S + 2;
                rd = board(m, flt, vb[0], vb[1], vb[2]);
                if (!vb[1]) ok = (rd[1] == vb[0]) && (m || (rd[0] == vb[0]));
                else        ok = !m || (rd[1] == vb[2]);
                if (!ok) begin
                    if (errs == 0) fv = vb;
                    if (errs < errmax) errs++;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pulse start, then count edges until done; optionally re-pulse start mid-run at edge inj.
    task automatic run_a(input logic m, input int flt, input int inj, output int cyc);
        a_jmp = m;
        a_flt = flt;
        @(negedge clk);
        a_if.start = 1'b1;
        a_if.mode  = m;
        @(posedge clk);
        #1;
        a_if.start = 1'b0;
        chk("busy_after_start", 32'(a_if.busy), 32'd1);
        cyc = 0;
        while (a_if.done !== 1'b1 && cyc < 2000) begin
            a_if.start = (cyc == inj);
            @(posedge clk);
            #1;
            cyc++;
        end
        a_if.start = 1'b0;
    endtask

    task automatic check_a(input string tag, input logic m, input int flt, input int cyc);
        int         ecyc;
        int         eerr;
        logic [2:0] efv;
        model(m, flt, 255, ecyc, eerr, efv);
        chk({tag, "_cycles"}, 32'(cyc), 32'(ecyc));
        chk({tag, "_done"}, 32'(a_if.done), 32'd1);
        chk({tag, "_err_cnt"}, 32'(a_if.err_cnt), 32'(eerr));
        chk({tag, "_fail_vec"}, 32'(a_if.fail_vec), 32'(efv));
        chk({tag, "_pass"}, 32'(a_if.pass), 32'(eerr == 0));
        chk({tag, "_fail"}, 32'(a_if.fail), 32'(eerr != 0));
    endtask

    initial begin
        int         cyc;
        int         ecyc;
        int         eerr;
        logic [2:0] efv;

        a_if.start = 1'b0;
        a_if.mode  = 1'b0;
        b_if.start = 1'b0;
        b_if.mode  = 1'b1;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_io_t", 32'(a_if.io_t), 32'd1);
        chk("rst_io_i", 32'(a_if.io_i), 32'd0);
        chk("rst_ext_o", 32'(a_if.ext_o), 32'd0);
        chk("rst_busy", 32'(a_if.busy), 32'd0);
        chk("rst_done", 32'(a_if.done), 32'd0);
        chk("rst_pass_fail", 32'({a_if.pass, a_if.fail}), 32'd0);
        chk("rst_err_cnt", 32'(a_if.err_cnt), 32'd0);
        chk("rst_fail_vec", 32'(a_if.fail_vec), 32'd0);
        rst = 1'b0;

`ifdef IOBUF_LOOPBACK_TESTER_CONTINUOUS_EN
        run_a(1'b0, 1, -1, cyc);
        check_a("cont_run1", 1'b0, 1, cyc);
        @(posedge clk);
        #1;
        chk("cont_done_pulse", 32'(a_if.done), 32'd0);
        chk("cont_restart_busy", 32'(a_if.busy), 32'd1);
        cyc = 1;
        while (a_if.done !== 1'b1 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        model(1'b0, 1, 255, ecyc, eerr, efv);
        chk("cont_run2_cycles", 32'(cyc), 32'(ecyc + 1));
        chk("cont_run2_err_cnt", 32'(a_if.err_cnt), 32'(2 * eerr));
        chk("cont_run2_fail_vec", 32'(a_if.fail_vec), 32'(efv));
        chk("cont_run2_fail", 32'(a_if.fail), 32'd1);
`else
        // Good jumper in mode 0, with a start pulse mid-run that must be ignored.
        run_a(1'b0, 0, 20, cyc);
        check_a("m0_good", 1'b0, 0, cyc);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_done", 32'(a_if.done), 32'd1);
        chk("hold_busy", 32'(a_if.busy), 32'd0);
        chk("hold_io_t", 32'(a_if.io_t), 32'd1);
        chk("hold_pass", 32'(a_if.pass), 32'd1);

        run_a(1'b1, 0, -1, cyc);
        check_a("m1_good", 1'b1, 0, cyc);

        run_a(1'b0, 1, -1, cyc);
        check_a("m0_ext_stuck0", 1'b0, 1, cyc);

        // Reset in the settle window of vector 3 after vector 1 has already failed.
        a_jmp = 1'b0;
        a_flt = 1;
        @(negedge clk);
        a_if.start = 1'b1;
        a_if.mode  = 1'b0;
        @(posedge clk);
        #1;
        a_if.start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("mid_busy", 32'(a_if.busy), 32'd1);
        chk("mid_err_cnt", 32'(a_if.err_cnt), 32'd1);
        chk("mid_io_i", 32'(a_if.io_i), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_io_t", 32'(a_if.io_t), 32'd1);
        chk("midrst_io_i", 32'(a_if.io_i), 32'd0);
        chk("midrst_busy", 32'(a_if.busy), 32'd0);
        chk("midrst_err_cnt", 32'(a_if.err_cnt), 32'd0);
        chk("midrst_fail_vec", 32'(a_if.fail_vec), 32'd0);
        chk("midrst_done", 32'(a_if.done), 32'd0);

        for (int i = 0; i < 4; i++) begin
            logic m;
            int   flt;
            m   = 1'($urandom_range(0, 1));
            flt = int'($urandom_range(0, 2));
            run_a(m, flt, int'($urandom_range(1, 100)), cyc);
            check_a($sformatf("rand%0d_m%0d_f%0d", i, m, flt), m, flt, cyc);
        end
`endif

        // Narrow counter: pad stuck high in mode 1 must saturate at 1.
        @(negedge clk);
        b_if.start = 1'b1;
        @(posedge clk);
        #1;
        b_if.start = 1'b0;
        cyc = 0;
        while (b_if.done !== 1'b1 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        model(1'b1, 2, 1, ecyc, eerr, efv);
        chk("sat_cycles", 32'(cyc), 32'(ecyc));
        chk("sat_err_cnt", 32'(b_if.err_cnt), 32'(eerr));
        chk("sat_fail_vec", 32'(b_if.fail_vec), 32'(efv));
        chk("sat_fail", 32'(b_if.fail), 32'd1);
        chk("sat_pass", 32'(b_if.pass), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
